// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer_32 block.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/serializer_32_if.sv
// Load handshake and serial output bundle of serializer_32.
interface serializer_32_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             serial_out;
    logic             frame;
    logic             done;

    modport master (
        output enable, load_valid, load_data,
        input  load_ready, serial_out, frame, done
    );

    modport slave (
        input  enable, load_valid, load_data,
        output load_ready, serial_out, frame, done
    );
endinterface

// File: rtl/serializer_32_bit_counter.sv
// Enable-gated bit counter with clear; flags the last data bit of a frame.
module ser_bit_counter #(
    parameter int WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;

    // Saturates at the last bit so it can never wrap inside a frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !last) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/serializer_32.sv
// MSB-first parallel-to-serial converter with enable-strobed bit advance.
// Optional even-parity bit after the data is compiled in with SERIALIZER_PARITY_EN.
module serializer_32
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    serializer_32_if.slave  bus
);
    ser_state_t       state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             serial_q, serial_next;
    logic             frame_q, frame_next;
    logic             done_q, done_next;
    logic             accept;
    logic             last_bit;

    assign bus.load_ready = (state == IDLE) && !reset;
    assign accept         = bus.load_valid && bus.load_ready;

    ser_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable ((state == SHIFT) && bus.enable),
        .last   (last_bit)
    );

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^bus.load_data;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            serial_q <= 1'b0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            serial_q <= serial_next;
            frame_q  <= frame_next;
            done_q   <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    shreg_next = bus.load_data;
                end
            end
            SHIFT: begin
                if (bus.enable) begin
                    shreg_next = {shreg[WIDTH-2:0], 1'b0};
                    if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                if (bus.enable) begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave flops directly.
        frame_next  = (state_next == SHIFT);
        serial_next = (state_next == SHIFT) ? shreg_next[WIDTH-1] : 1'b0;
        done_next   = (state_next == DONE);
`ifdef SERIALIZER_PARITY_EN
        if (state_next == PARITY) begin
            frame_next  = 1'b1;
            serial_next = parity_q;
        end
`endif
    end

    assign bus.serial_out = serial_q;
    assign bus.frame      = frame_q;
    assign bus.done       = done_q;
endmodule
